// File: rtl/boton_pulsos_if.sv
//==============================================================================
// Module      : boton_pulsos_if
// Description : Button-side bundle for the seconds-setting push-button
//               conditioner. Carries the two raw board-pin levels in and the
//               two clean one-cycle pulses out.
//   btn_up_raw       raw increment button (asynchronous, active-high)
//   btn_down_raw     raw decrement button (asynchronous, active-high)
//   boton_aumenta    registered one-cycle increment pulse
//   boton_disminuye  registered one-cycle decrement pulse
// Modports    : master = pin/stimulus side, slave = conditioner side
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface boton_pulsos_if;
  logic btn_up_raw;
  logic btn_down_raw;
  logic boton_aumenta;
  logic boton_disminuye;

  modport master (
    output btn_up_raw,
    output btn_down_raw,
    input  boton_aumenta,
    input  boton_disminuye
  );

  modport slave (
    input  btn_up_raw,
    input  btn_down_raw,
    output boton_aumenta,
    output boton_disminuye
  );
endinterface

`default_nettype wire

// File: rtl/boton_pulsos.sv
//==============================================================================
// Module      : boton_pulsos
// Description : Turns the two raw seconds-setting push-buttons into clean
//               one-cycle pulses. Each button is synchronized (2 flops),
//               debounced, edge-detected and auto-repeated while held.
//               Holding both buttons at once locks both out until each is
//               released.
// Ports       : clk    - single clock, rising edge
//               rst_n  - synchronous active-low reset
//               btn    - boton_pulsos_if.slave (raw buttons in, pulses out)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module boton_pulsos #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  boton_pulsos_if.slave btn
);

  // Counters fire when they reach N-1 so the action lands exactly N edges
  // after the count started.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

  // Bit 0 = up (aumenta), bit 1 = down (disminuye).
  logic [1:0] raw;
  logic [1:0] lvl_q_all;
  logic [1:0] lvl_d_all;
  logic [1:0] pulse_all;
  logic       lock;

  assign raw = {btn.btn_down_raw, btn.btn_up_raw};

  // Lock on either the current or the about-to-be-loaded debounced levels.
  // Looking at the next levels means an FSM stops pulsing on the very edge
  // where both levels become high, and it also rules out both FSMs seeing
  // a fresh press in the same cycle while the other button is releasing.
  assign lock = (&lvl_q_all) | (&lvl_d_all);

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             sync1_q, sync1_d;
    logic             sync_q,  sync_d;
    logic             lvl_q,   lvl_d;
    logic [CNT_W-1:0] dcnt_q,  dcnt_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] rcnt_q,  rcnt_d;
    logic             pulse_q, pulse_d;

    // Two-flop synchronizer.
    always_comb begin
      sync1_d = raw[i];
      sync_d  = sync1_q;
    end

    // Debounce: count consecutive cycles where sync disagrees with lvl;
    // any agreeing cycle restarts the count.
    always_comb begin
      lvl_d  = lvl_q;
      dcnt_d = '0;
      if (sync_q != lvl_q) begin
        if (dcnt_q == DEB_LAST) begin
          lvl_d = sync_q;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
    end

    // Press / auto-repeat FSM. rcnt_q counts down to the next repeat pulse.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Every exit from the other states requires lvl low, so lvl high
          // while idle is always a fresh rising edge.
          if (lvl_q) begin
            if (lock) begin
              state_d = ST_LOCK;
            end else begin
              pulse_d = 1'b1;
              rcnt_d  = DELAY_LOAD;
              state_d = ST_DELAY;
            end
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!lvl_q) begin
            state_d = ST_IDLE;
          end else if (lock) begin
            state_d = ST_LOCK;
          end else if (rcnt_q == '0) begin
            pulse_d = 1'b1;
            rcnt_d  = RATE_LOAD;
            state_d = ST_REPEAT;
          end else begin
            rcnt_d = rcnt_q - CNT_ONE;
          end
        end
        ST_LOCK: begin
          // Only this button's own release clears the lockout.
          if (!lvl_q) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync_q  <= 1'b0;
        lvl_q   <= 1'b0;
        dcnt_q  <= '0;
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= sync1_d;
        sync_q  <= sync_d;
        lvl_q   <= lvl_d;
        dcnt_q  <= dcnt_d;
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign lvl_q_all[i] = lvl_q;
    assign lvl_d_all[i] = lvl_d;
    assign pulse_all[i] = pulse_q;
  end

  assign btn.boton_aumenta   = pulse_all[0];
  assign btn.boton_disminuye = pulse_all[1];

endmodule

`default_nettype wire

// File: tb/tb_boton_pulsos.sv
//==============================================================================
// Module      : tb_boton_pulsos
// Description : Self-checking bench for boton_pulsos. Directed vector table
//               and hand-written multi-cycle sequences, followed by random
//               button activity, all compared against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_boton_pulsos;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  boton_pulsos_if bus ();

  boton_pulsos #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int q_up[$];
  int q_dn[$];
  int e_up[$];
  int e_dn[$];

  // Behavioural model: index 0 = up, 1 = down.
  bit         m_s1[2];
  bit         m_sync[2];
  bit         m_lvl[2];
  bit [D-1:0] m_win[2];
  int         m_nv[2];
  bit         m_act[2];
  bit         m_lk[2];
  int         m_p[2];
  bit         m_exp[2];

  typedef struct {
    bit up;
    bit dn;
    bit eu;
    bit ed;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_list(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({name, "_edge"}, got[i], exp[i]);
  endtask

  // lvl flips once the last D synchronized samples all disagree with it.
  // A press is paid out at its edge, then at RD after it and every RR after
  // that, until release or lockout.
  task automatic model_edge(input bit rn, input bit r0, input bit r1);
    bit raw[2];
    bit la[2];
    bit lk;
    int dd;
    raw[0] = r0;
    raw[1] = r1;
    if (!rn) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_sync[b] = 0; m_lvl[b] = 0; m_win[b] = '0; m_nv[b] = 0;
        m_act[b] = 0; m_lk[b] = 0; m_p[b] = 0; m_exp[b] = 0;
      end
      return;
    end
    for (int b = 0; b < 2; b++) begin
      m_win[b] = (m_win[b] << 1) | D'(m_sync[b]);
      if (m_nv[b] < D) m_nv[b]++;
      la[b] = m_lvl[b];
      if (m_nv[b] == D && m_win[b] == (m_lvl[b] ? {D{1'b0}} : {D{1'b1}}))
        la[b] = !m_lvl[b];
    end
    lk = (m_lvl[0] & m_lvl[1]) | (la[0] & la[1]);
    for (int b = 0; b < 2; b++) begin
      m_exp[b] = 0;
      if (!m_lvl[b]) begin
        m_act[b] = 0;
        m_lk[b]  = 0;
      end else if (m_lk[b]) begin
        m_act[b] = 0;
      end else if (lk) begin
        m_lk[b]  = 1;
        m_act[b] = 0;
      end else if (!m_act[b]) begin
        m_act[b] = 1;
        m_p[b]   = cyc;
        m_exp[b] = 1;
      end else begin
        dd = cyc - m_p[b];
        if (dd >= RD && (dd - RD) % RR == 0) m_exp[b] = 1;
      end
    end
    for (int b = 0; b < 2; b++) begin
      m_sync[b] = m_s1[b];
      m_s1[b]   = raw[b];
      m_lvl[b]  = la[b];
    end
  endtask

  task automatic step(input bit rn, input bit u, input bit d);
    rst_n            = rn;
    bus.btn_up_raw   = u;
    bus.btn_down_raw = d;
    @(posedge clk);
    cyc++;
    model_edge(rn, u, d);
    #1;
    check("aumenta", bus.boton_aumenta, m_exp[0]);
    check("disminuye", bus.boton_disminuye, m_exp[1]);
    check("exclusive", bus.boton_aumenta & bus.boton_disminuye, 0);
    if (bus.boton_aumenta === 1'b1) q_up.push_back(cyc);
    if (bus.boton_disminuye === 1'b1) q_dn.push_back(cyc);
  endtask

  task automatic clear_logs();
    q_up.delete(); q_dn.delete(); e_up.delete(); e_dn.delete();
  endtask

  initial begin
    int e0;
    int e1;
    int r;

    for (int i = 0; i < 12; i++)
      tbl[i] = '{up: (i < 10), dn: 1'b0, eu: (i == 6), ed: 1'b0};

    // Reset with both buttons held, then keep holding: lockout, no pulses.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1);
      check("reset_up", bus.boton_aumenta, 0);
      check("reset_dn", bus.boton_disminuye, 0);
    end
    for (int i = 0; i < 20; i++) step(1, 1, 1);
    check_list("reset_hold_up", q_up, e_up);
    check_list("reset_hold_dn", q_dn, e_dn);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Single press from the vector table.
    for (int i = 0; i < 12; i++) begin
      step(1, tbl[i].up, tbl[i].dn);
      check("tbl_up", bus.boton_aumenta, tbl[i].eu);
      check("tbl_dn", bus.boton_disminuye, tbl[i].ed);
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // Bounce: 3-high / 1-low three times, then a solid press.
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) step(1, 0, 1);
      step(1, 0, 0);
    end
    e0 = cyc + 1;
    for (int i = 0; i < 12; i++) step(1, 0, 1);
    e_dn.push_back(e0 + 6);
    check_list("bounce_dn", q_dn, e_dn);
    check_list("bounce_up", q_up, e_up);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Auto-repeat.
    clear_logs();
    e0 = cyc + 1;
    for (int i = 0; i < 60; i++) step(1, 1, 0);
    for (int i = 0; i < 25; i++) step(1, 0, 0);
    e_up = '{e0 + 6, e0 + 26, e0 + 31, e0 + 36, e0 + 41, e0 + 46, e0 + 51, e0 + 56, e0 + 61};
    check_list("repeat_up", q_up, e_up);
    check_list("repeat_dn", q_dn, e_dn);

    // Lockout: down lands its lock on the edge of a due up repeat pulse.
    clear_logs();
    e0 = cyc + 1;
    for (int i = 0; i < 41; i++) step(1, 1, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    e1 = cyc + 1;
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    e_up = '{e0 + 6, e0 + 26, e0 + 31, e0 + 36, e0 + 41, e1 + 6};
    check_list("lock_up", q_up, e_up);
    check_list("lock_dn", q_dn, e_dn);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Reset while repeating with the button still held.
    clear_logs();
    e0 = cyc + 1;
    for (int i = 0; i < 35; i++) step(1, 1, 0);
    r = cyc + 1;
    step(0, 1, 0);
    check("midreset_up", bus.boton_aumenta, 0);
    check("midreset_dn", bus.boton_disminuye, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    e_up = '{e0 + 6, e0 + 26, e0 + 31, r + 7, r + 27, r + 32, r + 37, r + 42};
    check_list("midreset_up", q_up, e_up);
    check_list("midreset_dn", q_dn, e_dn);

    // Random activity with glitches and occasional resets.
    for (int s = 0; s < 150; s++) begin
      int len;
      bit u;
      bit d;
      len = $urandom_range(40, 1);
      u   = 1'($urandom_range(1, 0));
      d   = ($urandom_range(2, 0) == 0);
      if ($urandom_range(39, 0) == 0) step(0, u, d);
      for (int k = 0; k < len; k++)
        step(1, u ^ ($urandom_range(15, 0) == 0), d ^ ($urandom_range(15, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
